// File: rtl/ps2_kb_pkg.sv
// ps2_kb_pkg: shared types and constants for the PS/2 keyboard receiver.
// Frame/decoder state enums, set-2 prefix and shift codes, and the
// scan-code to ASCII lookup. Shifted output is used only when the top
// is built with PS2_KB_SHIFT_EN defined.
package ps2_kb_pkg;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  // DEC_EXT_BRK covers "E0 F0 xx": the code after the F0 is skipped too.
  typedef enum logic [1:0] {
    DEC_NORM,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } ascii_t;

  // Set-2 make code to ASCII; hit=0 for codes with no character.
  function automatic ascii_t scan_to_ascii(input logic [7:0] code, input logic shift);
    ascii_t     r;
    logic [7:0] lo;
    logic [7:0] hi;
    r.hit = 1'b1;
    lo    = 8'h00;
    hi    = 8'h00;
    case (code)
      8'h1C: begin lo = "a"; hi = "A"; end
      8'h32: begin lo = "b"; hi = "B"; end
      8'h21: begin lo = "c"; hi = "C"; end
      8'h23: begin lo = "d"; hi = "D"; end
      8'h24: begin lo = "e"; hi = "E"; end
      8'h2B: begin lo = "f"; hi = "F"; end
      8'h34: begin lo = "g"; hi = "G"; end
      8'h33: begin lo = "h"; hi = "H"; end
      8'h43: begin lo = "i"; hi = "I"; end
      8'h3B: begin lo = "j"; hi = "J"; end
      8'h42: begin lo = "k"; hi = "K"; end
      8'h4B: begin lo = "l"; hi = "L"; end
      8'h3A: begin lo = "m"; hi = "M"; end
      8'h31: begin lo = "n"; hi = "N"; end
      8'h44: begin lo = "o"; hi = "O"; end
      8'h4D: begin lo = "p"; hi = "P"; end
      8'h15: begin lo = "q"; hi = "Q"; end
      8'h2D: begin lo = "r"; hi = "R"; end
      8'h1B: begin lo = "s"; hi = "S"; end
      8'h2C: begin lo = "t"; hi = "T"; end
      8'h3C: begin lo = "u"; hi = "U"; end
      8'h2A: begin lo = "v"; hi = "V"; end
      8'h1D: begin lo = "w"; hi = "W"; end
      8'h22: begin lo = "x"; hi = "X"; end
      8'h35: begin lo = "y"; hi = "Y"; end
      8'h1A: begin lo = "z"; hi = "Z"; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      default: r.hit = 1'b0;
    endcase
    r.ch = shift ? hi : lo;
    return r;
  endfunction

endpackage

// File: rtl/ps2_kb_rx_if.sv
// ps2_kb_rx_if: character handshake between the keyboard receiver
// (master, produces characters) and the keyboard/screen driver (slave).
interface ps2_kb_rx_if;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic       kb_ovf;
  logic       kb_ack;
  logic       ovf_clr;

  modport master (output kb_data, kb_valid, kb_ovf, input kb_ack, ovf_clr);
  modport slave  (input kb_data, kb_valid, kb_ovf, output kb_ack, ovf_clr);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins, detects falling ps2_clk edges
// and deframes 11-bit device-to-host frames (start, 8 data LSB first,
// odd parity, stop). Good frames pulse code_stb with the byte; bad
// start/parity/stop or an inter-edge timeout pulse frame_err.
module ps2_frame_rx
  import ps2_kb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_stb,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall_p1;
  logic                   data_p1;

  frame_state_t state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]   code_d;
  logic         stb_d;
  logic         err_d;

  // Pin synchronisers (idle-high) and registered falling-edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      fall_p1   <= 1'b0;
      data_p1   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      fall_p1   <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data_p1   <= data_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM and timeout: next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tmo_d     = '0;
    code_d    = code;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    if (state_q != FR_IDLE && !fall_p1) tmo_d = tmo_q + 1'b1;
    if (fall_p1) begin
      case (state_q)
        FR_IDLE: begin
          if (!data_p1) begin
            state_d   = FR_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        FR_DATA: begin
          shreg_d   = {data_p1, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
        end
        FR_PARITY: begin
          par_d   = data_p1;
          state_d = FR_STOP;
        end
        FR_STOP: begin
          if (data_p1 && (^{shreg_q, par_q})) begin
            stb_d  = 1'b1;
            code_d = shreg_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = FR_IDLE;
        end
        default: state_d = FR_IDLE;
      endcase
    end else if (state_q != FR_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = FR_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FR_IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      code      <= 8'h00;
      code_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      code      <= code_d;
      code_stb  <= stb_d;
      frame_err <= err_d;
    end
  end

endmodule

// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 keyboard receiver top. Deframes scan codes, decodes set-2
// make/break/extended sequences into ASCII and offers one character at a
// time on the kb_* handshake. Optional feature macro: PS2_KB_SHIFT_EN
// (tracks left/right shift and emits uppercase letters / shifted digits).
module ps2_kb_rx
  import ps2_kb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_kb_rx_if.master        kb,
  output logic               frame_err
);

  logic [7:0] code;
  logic       code_stb;

  dec_state_t dec_q, dec_d;
  ascii_t     look;
  logic       emit;
  logic [7:0] emit_ch;
  logic       shift;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_frame (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .code_stb (code_stb),
    .frame_err(frame_err)
  );

`ifdef PS2_KB_SHIFT_EN
  logic shift_set;
  logic shift_clr;

  // Shift key state: set on make, cleared on break of either shift key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         shift <= 1'b0;
    else if (shift_set) shift <= 1'b1;
    else if (shift_clr) shift <= 1'b0;
  end
`else
  assign shift = 1'b0;
`endif

  // Decoder FSM: classify each code as prefix, break target or make code.
  always_comb begin
    dec_d   = dec_q;
    emit    = 1'b0;
    emit_ch = 8'h00;
    look    = scan_to_ascii(code, shift);
`ifdef PS2_KB_SHIFT_EN
    shift_set = 1'b0;
    shift_clr = 1'b0;
`endif
    if (code_stb) begin
      case (dec_q)
        DEC_NORM: begin
          if (code == PS2_BREAK)    dec_d = DEC_BRK;
          else if (code == PS2_EXT) dec_d = DEC_EXT;
`ifdef PS2_KB_SHIFT_EN
          else if (code == PS2_LSHIFT || code == PS2_RSHIFT) shift_set = 1'b1;
`endif
          else if (look.hit) begin
            emit    = 1'b1;
            emit_ch = look.ch;
          end
        end
        DEC_BRK: begin
`ifdef PS2_KB_SHIFT_EN
          if (code == PS2_LSHIFT || code == PS2_RSHIFT) shift_clr = 1'b1;
`endif
          dec_d = DEC_NORM;
        end
        DEC_EXT:     dec_d = (code == PS2_BREAK) ? DEC_EXT_BRK : DEC_NORM;
        DEC_EXT_BRK: dec_d = DEC_NORM;
        default:     dec_d = DEC_NORM;
      endcase
    end
  end

  // Decoder FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= DEC_NORM;
    else        dec_q <= dec_d;
  end

  // Output handshake: load on free slot (or same-cycle ack), else overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb.kb_data  <= 8'h00;
      kb.kb_valid <= 1'b0;
      kb.kb_ovf   <= 1'b0;
    end else begin
      if (emit && (!kb.kb_valid || kb.kb_ack)) begin
        kb.kb_data  <= emit_ch;
        kb.kb_valid <= 1'b1;
      end else if (kb.kb_ack) begin
        kb.kb_valid <= 1'b0;
      end
      if (emit && kb.kb_valid && !kb.kb_ack) kb.kb_ovf <= 1'b1;
      else if (kb.ovf_clr)                   kb.kb_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kb_rx.sv
// tb_ps2_kb_rx: directed plus randomized bench for ps2_kb_rx. Frames are
// bit-banged on the PS/2 pins; expected characters come from a table-driven
// model of the set-2 decoding rules.
module tb_ps2_kb_rx;
  localparam int S    = 2;
  localparam int TMO  = 400;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic frame_err;

  ps2_kb_rx_if kb ();

  ps2_kb_rx #(.SYNC_STAGES(S), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kb       (kb),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  int err_cnt = 0;
  int err_run = 0;
  int err_max = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_run++;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] lo_map [logic [7:0]];
  logic [7:0] hi_map [logic [7:0]];
  int m_mode;   // 0 normal, 1 after F0, 2 after E0, 3 after E0 F0
  bit m_shift;

  task automatic init_model();
    string      letters = "abcdefghijklmnopqrstuvwxyz";
    string      dlo = "0123456789";
    string      dhi = ")!@#$%^&*(";
    logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                            8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) begin
      lo_map[lc[i]] = letters[i];
      hi_map[lc[i]] = letters[i] - 8'd32;
    end
    for (int i = 0; i < 10; i++) begin
      lo_map[dc[i]] = dlo[i];
      hi_map[dc[i]] = dhi[i];
    end
    lo_map[8'h29] = 8'h20; hi_map[8'h29] = 8'h20;
    lo_map[8'h5A] = 8'h0D; hi_map[8'h5A] = 8'h0D;
    lo_map[8'h66] = 8'h08; hi_map[8'h66] = 8'h08;
    m_mode  = 0;
    m_shift = 0;
  endtask

  function automatic bit is_shift_key(input logic [7:0] c);
`ifdef PS2_KB_SHIFT_EN
    return (c == 8'h12) || (c == 8'h59);
`else
    return (c == 8'h12) && (c == 8'h59);
`endif
  endfunction

  task automatic model_feed(input logic [7:0] c, output bit emit, output logic [7:0] ch);
    emit = 0;
    ch   = 8'h00;
    if (m_mode == 1) begin
      if (is_shift_key(c)) m_shift = 0;
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_mode = (c == 8'hF0) ? 3 : 0;
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (c == 8'hF0) begin
      m_mode = 1;
    end else if (c == 8'hE0) begin
      m_mode = 2;
    end else if (is_shift_key(c)) begin
      m_shift = 1;
    end else if (lo_map.exists(c)) begin
      emit = 1;
      ch   = m_shift ? hi_map[c] : lo_map[c];
    end
  endtask

  // ---------------- pin drivers ----------------
  function automatic logic [10:0] mkframe(input logic [7:0] d, input bit badpar, input bit badstop);
    logic par;
    par = (~^d) ^ badpar;
    return {~badstop, par, d, 1'b0};
  endfunction

  task automatic pulse_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) pulse_bit(f[i]);
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(mkframe(d, 1'b0, 1'b0), 11);
  endtask

  task automatic ack();
    @(negedge clk) kb.kb_ack = 1'b1;
    @(negedge clk) kb.kb_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         lat;
    int         e0;
    bit         m_emit;
    logic [7:0] m_ch;
    logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66,
                              8'h12, 8'h59, 8'hF0, 8'hE0, 8'h00, 8'h76, 8'h1A, 8'h3E};
    logic [7:0] c;

    kb.kb_ack  = 1'b0;
    kb.ovf_clr = 1'b0;
    init_model();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(kb.kb_data), 32'h00);
    check("rst_valid", 32'(kb.kb_valid), 32'h0);
    check("rst_ovf", 32'(kb.kb_ovf), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x1C with stop-edge latency measurement
    for (int i = 0; i < 10; i++) pulse_bit(mkframe(8'h1C, 1'b0, 1'b0)[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge clk);
      #1;
      if (kb.kb_valid === 1'b1) break;
    end
    check("latency", 32'(lat), 32'(S + 3));
    check("a_data", 32'(kb.kb_data), 32'h61);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk) kb.kb_ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack_clears", 32'(kb.kb_valid), 32'h0);
    @(negedge clk) kb.kb_ack = 1'b0;

    // make / break / make of the same key: one character
    send_frame(8'h1C);
    check("mk_valid", 32'(kb.kb_valid), 32'h1);
    check("mk_data", 32'(kb.kb_data), 32'h61);
    ack();
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("brk_no_char", 32'(kb.kb_valid), 32'h0);

`ifdef PS2_KB_SHIFT_EN
    send_frame(8'h12);
    send_frame(8'h1C);
    check("shift_A", 32'(kb.kb_data), 32'h41);
    ack();
    send_frame(8'hF0);
    send_frame(8'h12);
    send_frame(8'h1C);
    check("unshift_a_v", 32'(kb.kb_valid), 32'h1);
    check("unshift_a", 32'(kb.kb_data), 32'h61);
    ack();
`endif

    // parity error
    e0 = err_cnt;
    err_max = 0;
    send_bits(mkframe(8'h1C, 1'b1, 1'b0), 11);
    check("par_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("par_err_width", 32'(err_max), 32'd1);
    check("par_no_char", 32'(kb.kb_valid), 32'h0);

    // stop error
    e0 = err_cnt;
    send_bits(mkframe(8'h32, 1'b0, 1'b1), 11);
    check("stop_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("stop_no_char", 32'(kb.kb_valid), 32'h0);

    // falling edge in idle with data high: bad start
    e0 = err_cnt;
    send_bits(11'h7FF, 1);
    check("start_err_cnt", 32'(err_cnt - e0), 32'd1);

    // overflow and clear
    send_frame(8'h1C);
    send_frame(8'h32);
    check("ovf_data", 32'(kb.kb_data), 32'h61);
    check("ovf_set", 32'(kb.kb_ovf), 32'h1);
    @(negedge clk) kb.ovf_clr = 1'b1;
    @(negedge clk) kb.ovf_clr = 1'b0;
    check("ovf_clr", 32'(kb.kb_ovf), 32'h0);
    ack();

    // timeout after five bits, then a clean 0x29
    e0 = err_cnt;
    err_max = 0;
    send_bits(mkframe(8'h55, 1'b0, 1'b0), 5);
    for (int k = 0; k < TMO + 100; k++) begin
      @(negedge clk);
      if (err_cnt != e0) break;
    end
    repeat (5) @(negedge clk);
    check("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("tmo_err_width", 32'(err_max), 32'd1);
    send_frame(8'h29);
    check("space_data", 32'(kb.kb_data), 32'h20);
    check("space_valid", 32'(kb.kb_valid), 32'h1);
    ack();

    // reset in mid-frame with outputs non-zero
    send_frame(8'h1C);
    send_frame(8'h32);
    send_bits(mkframe(8'h5A, 1'b0, 1'b0), 4);
    e0 = err_cnt;
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mrst_data", 32'(kb.kb_data), 32'h00);
    check("mrst_valid", 32'(kb.kb_valid), 32'h0);
    check("mrst_ovf", 32'(kb.kb_ovf), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TMO + 20) @(negedge clk);
    check("mrst_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h5A);
    check("enter_data", 32'(kb.kb_data), 32'h0D);
    ack();
    m_mode  = 0;
    m_shift = 0;

    // randomized code stream against the model
    for (int n = 0; n < 40; n++) begin
      c = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      send_frame(c);
      model_feed(c, m_emit, m_ch);
      check($sformatf("rnd%0d_valid_%02h", n, c), 32'(kb.kb_valid), 32'(m_emit));
      if (m_emit) begin
        check($sformatf("rnd%0d_data_%02h", n, c), 32'(kb.kb_data), 32'(m_ch));
        ack();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_kb_rx.md
# ps2_kb_rx

PS/2 keyboard receiver and scan-code decoder that sits directly upstream of the keyboard/screen driver. It synchronises the raw PS/2 clock and data pins and deframes 11-bit device-to-host frames. It translates set-2 make codes into ASCII and presents one character at a time on a valid/ack handshake. The driver loads that character into its keyboard data register.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronisers (≥2)
- TIMEOUT_CYC, 100000, clk cycles with no falling ps2_clk edge before a partial frame is abandoned (2 ms at 50 MHz)
- clk  in  1  system clock; one clock domain, everything rising-edge
- rst_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- kb_ack  in  1  driver has taken kb_data; one-cycle pulse
- ovf_clr  in  1  clears kb_ovf
- kb_data  out  8  ASCII character
- kb_valid  out  1  kb_data holds an unconsumed character
- kb_ovf  out  1  sticky; a character was dropped because kb_valid was still set
- frame_err  out  1  one-cycle pulse on bad start, parity, stop or timeout

## Operation
- Reset: kb_data=0x00, kb_valid=0, kb_ovf=0, frame_err=0, both FSMs idle, shift=0, synchronisers load 1.
- Frame FSM states: IDLE, DATA, PARITY, STOP. Bits are sampled on each detected falling edge of synchronised ps2_clk.
  - IDLE: sampled 0 -> DATA, bit count 0. Sampled 1 -> stay in IDLE and pulse frame_err.
  - DATA: 8 bits, LSB first, then -> PARITY.
  - PARITY: odd parity over the 8 data bits and the parity bit.
  - STOP: stop must be 1. A good frame emits code_stb with the byte. A bad parity or stop bit pulses frame_err and emits nothing. Either way -> IDLE.
  - Timeout: TIMEOUT_CYC cycles without a falling edge while not in IDLE -> IDLE and pulse frame_err.
- Decoder FSM states: NORM, BRK (after 0xF0), EXT (after 0xE0).
  - EXT: the next code is discarded. If that code is 0xF0, the one after is also discarded. Then -> NORM.
  - BRK: the code is consumed and produces no character. Shift break (0x12/0x59) clears shift. Then -> NORM.
  - NORM, mapped make code: emits a character.
  - NORM, unmapped code: dropped silently.
- Map (lowercase):
  - a–z per set 2 (0x1C→'a', 0x32→'b', … 0x1A→'z')
  - digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → '0'–'9'
  - 0x29→0x20, 0x5A→0x0D, 0x66→0x08
- Handshake:
  - An emitted character loads kb_data and sets kb_valid.
  - kb_ack while kb_valid=1 clears kb_valid next cycle. kb_ack while kb_valid=0 is ignored.
  - New character while kb_valid=1 and no ack: the character is dropped, kb_data is unchanged, kb_ovf sets.
  - New character and kb_ack in the same cycle: the new character loads, kb_valid stays 1, no overflow.
  - ovf_clr and an overflow in the same cycle: kb_ovf ends set.

## Timing
- The falling edge is detected SYNC_STAGES+1 clk cycles after the pin edge.
- code_stb asserts the cycle after the stop-bit edge is detected. kb_valid/kb_data register one cycle after code_stb.
- Total latency from the pin's stop-bit falling edge to kb_valid=1 is SYNC_STAGES+3 cycles.
- frame_err is high for exactly one cycle.
- rst_n asserted mid-frame: immediate return to the reset state. A partial frame is lost and no frame_err is raised.

## Configuration
- PS2_KB_SHIFT_EN defined:
  - make 0x12/0x59 sets shift; their break clears it
  - with shift held, letters map to 'A'–'Z' and digits to ")!@#$%^&*("
- Undefined: the shift register is absent, shift codes are dropped as unmapped, and output is always lowercase/digit.

## Structure
- Package ps2_kb_pkg: frame and decoder state enums, PS2_BREAK=8'hF0, PS2_EXT=8'hE0, shift code constants, and the scan-to-ASCII lookup function(s).
- Sub-module ps2_frame_rx: synchronisers, edge detect, frame FSM, timeout counter. Outputs code, code_stb and frame_err.
- The top level holds the decoder FSM, shift state and output handshake.

## Test plan
- Frame 0x1C (parity 0, stop 1) -> kb_data=0x61, kb_valid=1 SYNC_STAGES+3 cycles after the stop edge. kb_ack -> kb_valid=0 next cycle.
- Frames 0x1C, 0xF0, 0x1C -> exactly one character 0x61. With SHIFT_EN, frames 0x12, 0x1C, 0xF0, 0x12, 0x1C -> 0x41 then 0x61.
- Frame 0x1C with parity 1 -> frame_err one-cycle pulse, kb_valid stays 0.
- Frames 0x1C then 0x32 with no ack -> kb_data=0x61, kb_ovf=1. ovf_clr -> kb_ovf=0.
- Five bits then silence for TIMEOUT_CYC -> frame_err pulse. A following full 0x29 frame -> kb_data=0x20.
- rst_n low after 4 bits -> all outputs 0. A full 0x5A frame after release -> kb_data=0x0D.
